// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the single-cycle CPU core.
// Owns the PC, feeds it to the core and commits the core's next address
// once per executed instruction. Supports start/step/cont/halt, a retired
// instruction limit, one address breakpoint and self-loop detection.
module cpu_run_ctrl #(
  parameter int ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              cont,
  input  logic              halt_req,
  input  logic [CNT_W-1:0]  max_instr,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] core_addr_o,
  output logic [ADDR_W-1:0] core_addr_i,
  output logic              core_en,
  output logic              running,
  output logic              halted,
  output logic [1:0]        halt_reason,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [1:0] RSN_NONE  = 2'd0;
  localparam logic [1:0] RSN_HOST  = 2'd1;
  localparam logic [1:0] RSN_BP    = 2'd2;
  localparam logic [1:0] RSN_LIMIT = 2'd3;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [CNT_W-1:0]    r_retired;
  logic [1:0]          r_reason;
  logic                r_bp_skip;

  logic                w_bp_hit;
  logic                w_commit;
  logic                w_self_loop;
  logic                w_limit;

  // Breakpoint, commit enable and RUN-exit conditions from current state
  always_comb begin
    w_bp_hit    = bp_en && (r_pc == bp_addr) && !r_bp_skip;
    w_commit    = ((r_state == S_RUN) && !w_bp_hit) || (r_state == S_STEP);
    w_self_loop = (core_addr_o == r_pc);
    w_limit     = (max_instr != '0) && ((r_retired + CNT_W'(1)) == max_instr);
  end

  // State machine, PC commit, retired counter and halt reason
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_retired <= '0;
      r_reason  <= RSN_NONE;
      r_bp_skip <= 1'b0;
    end else begin
      if (w_commit) begin
        r_pc <= core_addr_o;
        if (r_retired != '1) r_retired <= r_retired + CNT_W'(1);
      end
      case (r_state)
        S_IDLE, S_HALT: begin
          // core_en is low here, so the start PC load cannot collide with a commit
          if (start) begin
            r_state   <= S_RUN;
            r_pc      <= RESET_PC;
            r_retired <= '0;
            r_reason  <= RSN_NONE;
            r_bp_skip <= 1'b0;
          end else if (step) begin
            r_state <= S_STEP;
          end else if (cont && (r_state == S_HALT)) begin
            r_state   <= S_RUN;
            r_bp_skip <= 1'b1;
          end
        end
        S_STEP: begin
          r_state  <= S_HALT;
          r_reason <= RSN_HOST;
        end
        S_RUN: begin
          r_bp_skip <= 1'b0;
          if (w_bp_hit) begin
            r_state  <= S_HALT;
            r_reason <= RSN_BP;
          end else if (w_self_loop || w_limit) begin
            r_state  <= S_HALT;
            r_reason <= RSN_LIMIT;
          end else if (halt_req) begin
            r_state  <= S_HALT;
            r_reason <= RSN_HOST;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_addr_i = r_pc;
  assign core_en     = w_commit;
  assign running     = (r_state == S_RUN) || (r_state == S_STEP);
  assign halted      = (r_state == S_HALT);
  assign halt_reason = r_reason;
  assign retired     = r_retired;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus randomized control
// traffic, checked every cycle against a behavioural model.
module tb_cpu_run_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, step, cont, halt_req, bp_en;
  logic [CNT_W-1:0]  max_instr;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] core_addr_o;
  logic [ADDR_W-1:0] core_addr_i;
  logic              core_en, running, halted;
  logic [1:0]        halt_reason;
  logic [CNT_W-1:0]  retired;
  logic [ADDR_W-1:0] loop_addr = 32'h1;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_on   = 1'b0;

  cpu_run_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .cont(cont),
    .halt_req(halt_req), .max_instr(max_instr), .bp_en(bp_en), .bp_addr(bp_addr),
    .core_addr_o(core_addr_o), .core_addr_i(core_addr_i), .core_en(core_en),
    .running(running), .halted(halted), .halt_reason(halt_reason), .retired(retired)
  );

  always #5 clk = ~clk;

  // Toy core: sequential +4 within a 256-byte window, branch-to-self at loop_addr
  function automatic logic [31:0] core_next(logic [31:0] a, logic [31:0] la);
    return (a == la) ? a : ((a + 32'd4) & 32'h0000_00FF);
  endfunction

  assign core_addr_o = core_next(core_addr_i, loop_addr);

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running free, 2 single step pending, 3 halted
  int          m_mode;
  logic [31:0] m_pc;
  int          m_ret;
  int          m_reason;
  bit          m_skip;
  bit          m_hit, m_exec;
  logic [31:0] m_nxt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_ret = 0; m_reason = 0; m_skip = 0;
    end else begin
      m_hit  = (m_mode == 1) && bp_en && (m_pc == bp_addr) && !m_skip;
      m_exec = ((m_mode == 1) && !m_hit) || (m_mode == 2);
      m_nxt  = core_next(m_pc, loop_addr);
      if (m_mode == 0 || m_mode == 3) begin
        if (start) begin
          m_mode = 1; m_pc = 0; m_ret = 0; m_reason = 0; m_skip = 0;
        end else if (step) m_mode = 2;
        else if (cont && m_mode == 3) begin
          m_mode = 1; m_skip = 1;
        end
      end else if (m_mode == 2) begin
        m_pc = m_nxt; m_ret = (m_ret < 65535) ? m_ret + 1 : m_ret;
        m_mode = 3; m_reason = 1;
      end else begin
        m_skip = 0;
        if (m_hit) begin
          m_mode = 3; m_reason = 2;
        end else begin
          if ((m_nxt == m_pc) || (max_instr != 0 && m_ret + 1 == int'(max_instr))) begin
            m_mode = 3; m_reason = 3;
          end else if (halt_req) begin
            m_mode = 3; m_reason = 1;
          end
          m_pc = m_nxt; m_ret = (m_ret < 65535) ? m_ret + 1 : m_ret;
        end
      end
    end
    if (m_exec && !rst_n) m_exec = 0;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negative edge, DUT outputs against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("pc",      64'(core_addr_i), 64'(m_pc));
      chk("core_en", 64'(core_en), 64'((m_mode == 1 && !(bp_en && m_pc == bp_addr && !m_skip)) || m_mode == 2));
      chk("running", 64'(running), 64'(m_mode == 1 || m_mode == 2));
      chk("halted",  64'(halted), 64'(m_mode == 3));
      chk("reason",  64'(halt_reason), 64'(m_reason));
      chk("retired", 64'(retired), 64'(m_ret));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_halt(int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    chk("wait_halt", 64'(halted), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; step = 0; cont = 0; halt_req = 0;
    bp_en = 0; bp_addr = '0; max_instr = '0;
    #1;
    chk("rst_pc", 64'(core_addr_i), 64'h0);
    chk("rst_en", 64'(core_en), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    cmp_on = 1'b1;
    tick();
    chk("idle_halted", 64'(halted), 64'd0);
    chk("idle_running", 64'(running), 64'd0);

    // Sequential run of 23 instructions, then host halt
    pulse_start();
    repeat (22) tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("seq_pc", 64'(core_addr_i), 64'h5C);
    chk("seq_ret", 64'(retired), 64'd23);
    chk("seq_reason", 64'(halt_reason), 64'd1);
    chk("seq_halted", 64'(halted), 64'd1);

    // Instruction limit of 5
    max_instr = 16'd5;
    pulse_start();
    wait_halt(50);
    chk("lim_pc", 64'(core_addr_i), 64'h14);
    chk("lim_ret", 64'(retired), 64'd5);
    chk("lim_reason", 64'(halt_reason), 64'd3);
    tick();
    chk("lim_en_low", 64'(core_en), 64'd0);
    max_instr = '0;

    // Breakpoint at 0x10, then resume past it
    bp_en = 1'b1; bp_addr = 32'h10;
    pulse_start();
    wait_halt(50);
    chk("bp_pc", 64'(core_addr_i), 64'h10);
    chk("bp_ret", 64'(retired), 64'd4);
    chk("bp_reason", 64'(halt_reason), 64'd2);
    cont = 1'b1; tick(); cont = 1'b0;
    tick();
    chk("cont_pc1", 64'(core_addr_i), 64'h14);
    tick();
    chk("cont_pc2", 64'(core_addr_i), 64'h18);
    chk("cont_running", 64'(running), 64'd1);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    bp_en = 1'b0;

    // Halt at 0x20 via limit, then three single steps
    max_instr = 16'd8;
    pulse_start();
    wait_halt(50);
    chk("s0_pc", 64'(core_addr_i), 64'h20);
    max_instr = '0;
    for (int i = 1; i <= 3; i++) begin
      step = 1'b1; tick(); step = 1'b0;
      chk("step_running", 64'(running), 64'd1);
      tick();
      chk("step_pc", 64'(core_addr_i), 64'(32'h20 + 4 * i));
      chk("step_ret", 64'(retired), 64'(8 + i));
      chk("step_reason", 64'(halt_reason), 64'd1);
    end
    step = 1'b1; start = 1'b1; tick(); step = 1'b0; start = 1'b0;
    chk("restart_pc", 64'(core_addr_i), 64'h0);
    chk("restart_ret", 64'(retired), 64'd0);
    halt_req = 1'b1; tick(); halt_req = 1'b0;

    // Branch-to-self at 0x30
    loop_addr = 32'h30;
    pulse_start();
    wait_halt(50);
    chk("loop_pc", 64'(core_addr_i), 64'h30);
    chk("loop_reason", 64'(halt_reason), 64'd3);
    chk("loop_ret", 64'(retired), 64'd13);
    loop_addr = 32'h1;

    // Asynchronous reset while running at 0x40
    pulse_start();
    repeat (16) tick();
    chk("pre_rst_pc", 64'(core_addr_i), 64'h40);
    rst_n = 1'b0;
    #1;
    chk("arst_pc", 64'(core_addr_i), 64'h0);
    chk("arst_en", 64'(core_en), 64'd0);
    chk("arst_run", 64'(running), 64'd0);
    chk("arst_ret", 64'(retired), 64'd0);
    chk("arst_reason", 64'(halt_reason), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized control traffic
    for (int c = 0; c < 4000; c++) begin
      start    = ($urandom_range(0, 19) == 0);
      step     = ($urandom_range(0, 9) == 0);
      cont     = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 49) == 0)
        max_instr = ($urandom_range(0, 1) == 0) ? '0 : 16'($urandom_range(1, 40));
      if ($urandom_range(0, 39) == 0) begin
        bp_en   = 1'($urandom_range(0, 1));
        bp_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if ($urandom_range(0, 99) == 0)
        loop_addr = ($urandom_range(0, 2) == 0) ? (32'($urandom_range(0, 63)) << 2) : 32'h1;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0; #2; rst_n = 1'b1;
      end
      tick();
    end
    start = 0; step = 0; cont = 0; halt_req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step controller that sequences the single-cycle CPU core. Owns the program counter register, drives the core's instruction address input, and commits the core's next-address output once per executed instruction, replacing the manual per-cycle feedback of address out to address in. Provides start, single-step, continue and halt control, a retired-instruction limit, one address breakpoint and end-of-program (self-loop) detection; sits between the debug/test host and the core.

## Interface

- ADDR_W, 32, address width of core address in/out
- RESET_PC, 0, PC value loaded at reset and on start
- CNT_W, 16, width of retired counter and instruction limit

- clk  in  1  rising-edge clock, shared with the core
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  restart program at RESET_PC and run (pulse)
- step  in  1  execute exactly one instruction (pulse)
- cont  in  1  resume running from current PC (pulse)
- halt_req  in  1  stop running after the current instruction
- max_instr  in  CNT_W  retired-instruction limit; 0 = unlimited
- bp_en  in  1  breakpoint enable
- bp_addr  in  ADDR_W  breakpoint PC
- core_addr_o  in  ADDR_W  next-address output of the core (combinational from addr_i)
- core_addr_i  out  ADDR_W  current PC to the core; registered
- core_en  out  1  commit enable to the core (gates core register/memory writes)
- running  out  1  state is RUN or STEP
- halted  out  1  state is HALT
- halt_reason  out  2  0 none, 1 host (halt_req/step done), 2 breakpoint, 3 limit or self-loop
- retired  out  CNT_W  instructions committed since last start; saturates at all-ones

## Operation

- States: IDLE, RUN, STEP, HALT. Reset enters IDLE.
- Commit: any cycle with core_en=1, at rising edge: pc <= core_addr_o, retired <= retired+1 (saturating). core_addr_i = pc always.
- core_en (combinational) = (state==RUN and not bp_hit) or state==STEP. bp_hit = bp_en and pc==bp_addr and not bp_skip.
- IDLE/HALT: start -> RUN with pc <= RESET_PC, retired <= 0, halt_reason <= 0, bp_skip <= 0. Else step -> STEP. Else cont (HALT only) -> RUN, bp_skip <= 1. Priority start > step > cont; cont in IDLE ignored.
- STEP: commits one instruction (breakpoint not checked), then HALT, reason 1.
- RUN, evaluated per cycle in priority order:
  1. bp_hit: no commit, -> HALT, reason 2.
  2. otherwise commit; then if core_addr_o==pc (self-loop) or (max_instr!=0 and retired+1==max_instr): -> HALT, reason 3.
  3. else if halt_req: -> HALT, reason 1.
  4. else stay RUN.
- bp_skip clears after the first RUN cycle following cont, so resuming from a breakpoint executes the breakpoint instruction once.
- start/step/cont while in RUN or STEP are ignored; halt_req outside RUN ignored.

## Timing

- Reset (async assert, any state): pc=RESET_PC, state IDLE, core_en=0, running=0, halted=0, halt_reason=0, retired=0, bp_skip=0; core_addr_i=RESET_PC immediately.
- Control pulses sampled at the rising edge; first commit occurs on the edge one cycle after start/step/cont edge.
- RUN throughput: one instruction per cycle; core_addr_i updates the edge of each commit.
- Halt latency: halt_req high at edge N commits instruction N, HALT visible after edge N.
- Breakpoint: HALT visible one edge after pc reaches bp_addr; pc stays bp_addr, retired unchanged.
- Limit: halts on the edge committing the max_instr-th instruction; retired==max_instr.
- Reset deasserted mid-program discards all progress; no partial commit.

## Test plan

- Sequential program (core next = pc+4), start, max_instr=0, run 23 cycles then halt_req -> core_addr_i sequence 0,4,...,0x58 one per cycle; HALT, retired=23, reason 1.
- max_instr=5, start -> HALT after 5 commits, pc=0x14, retired=5, reason 3; core_en low afterwards.
- bp_en=1, bp_addr=0x10, start -> HALT with pc=0x10, retired=4, reason 2; cont -> executes 0x10, continues to 0x14, 0x18 without re-hitting.
- From HALT at 0x20, three step pulses -> pc 0x24, 0x28, 0x2C, each followed by HALT reason 1, retired +1 each; step and start same edge -> restarts at 0.
- Core branch-to-self at 0x30 (core_addr_o==0x30) -> HALT reason 3, pc=0x30.
- rst_n asserted while RUN at pc=0x40 -> outputs return to reset values asynchronously; core_en=0 before next edge.
